// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in/parallel-out deserializer.
// Holds the FSM state encoding, default width and counter-width helper.
package sipo_pkg;

  typedef enum logic {
    IDLE,
    RECV
  } sipo_state_t;

  localparam int SIPO_DEF_WIDTH = 4;

  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/sipo_hold_reg.sv
// One-entry valid/ready holding register for completed words.
// Flags a drop when a word arrives while full and not draining.
module sipo_hold_reg
  import sipo_pkg::*;
#(
  parameter int WIDTH = SIPO_DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_word,
  input  logic             in_vld,
  output logic [WIDTH-1:0] out_word,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic             drop
);

  logic [WIDTH-1:0] word_q;
  logic             vld_q;
  logic             can_load;

  assign can_load = !vld_q || out_rdy;
  assign drop     = in_vld && !can_load;
  assign out_word = word_q;
  assign out_vld  = vld_q;

  // Load when there is room (including same-cycle drain), else hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      word_q <= '0;
      vld_q  <= 1'b0;
    end else if (in_vld && can_load) begin
      word_q <= in_word;
      vld_q  <= 1'b1;
    end else if (vld_q && out_rdy) begin
      vld_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/sipo_deser.sv
// Serial-in/parallel-out deserializer with sof framing resync.
// Words complete into a 1-entry holding register; drops set sticky ovf.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH     = SIPO_DEF_WIDTH,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sin,
  input  logic             sin_vld,
  input  logic             sof,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             busy,
  output logic             ovf,
  input  logic             clr_ovf
);

  localparam int CW = cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sipo_state_t      state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] shifted, first;
  logic             ovf_q, ovf_d;
  logic             done;
  logic             drop;

  // Bit placement depends on the serial order.
  always_comb begin
    if (MSB_FIRST) begin
      shifted = {sr_q[WIDTH-2:0], sin};
      first   = {{(WIDTH-1){1'b0}}, sin};
    end else begin
      shifted = {sin, sr_q[WIDTH-1:1]};
      first   = {sin, {(WIDTH-1){1'b0}}};
    end
  end

  // Framing FSM: count bits, restart on sof, flag completion.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sr_d    = sr_q;
    done    = 1'b0;
    if (sin_vld) begin
      if (sof) begin
        sr_d    = first;
        cnt_d   = CW'(1);
        state_d = RECV;
      end else begin
        sr_d = shifted;
        unique case (state_q)
          IDLE: begin
            cnt_d   = CW'(1);
            state_d = RECV;
          end
          RECV: begin
            if (cnt_q == LAST) begin
              cnt_d   = '0;
              state_d = IDLE;
              done    = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  // Sticky overflow: a new drop beats a clear.
  always_comb begin
    ovf_d = ovf_q;
    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  // State, counter, shift register and ovf flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sr_q    <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sr_q    <= sr_d;
      ovf_q   <= ovf_d;
    end
  end

  sipo_hold_reg #(
    .WIDTH(WIDTH)
  ) u_hold (
    .clk     (clk),
    .rst     (rst),
    .in_word (sr_d),
    .in_vld  (done),
    .out_word(dout),
    .out_vld (dout_vld),
    .out_rdy (dout_rdy),
    .drop    (drop)
  );

  assign busy = (cnt_q != '0);
  assign ovf  = ovf_q;

endmodule
